karatsuba_seq: RTL and testbench
================================

Name: karatsuba_seq

Overview:
- Parametrised, multi-cycle Karatsuba multiplier. Next generation of the fixed 8-bit Karatsuba block.
- Computes Z = X*Y for WIDTH-bit operands, unsigned or signed (selected per operation), using one shared (WIDTH/2+1)-bit multiplier over three cycles.
- Start/busy/done handshake so a controller or datapath FSM can issue back-to-back products.

Parameters:
- WIDTH, 8, operand width. Must be even and >= 4; any other value is an elaboration error.
- SIGNED_EN, 1, 1 = honour the is_signed input; 0 = is_signed ignored, always unsigned.

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands; sampled with start
- X  input  WIDTH  multiplicand; sampled with start
- Y  input  WIDTH  multiplier; sampled with start
- busy  output  1  high from the cycle after start is accepted until the result is written
- done  output  1  one-cycle pulse when Z is updated
- Z  output  2*WIDTH  product, registered, held until the next done

Behaviour:
- Reset (synchronous, rising edge with reset=1): state=IDLE, busy=0, done=0, Z=0, all internal registers cleared. Reset overrides start and any in-flight operation; no done is produced for an aborted operation.
- H = WIDTH/2. Operands split as A = Ah*2^H + Al and B = Bh*2^H + Bl.
- FSM states and transitions:
  - IDLE: if start=1, capture X, Y, sgn = is_signed & SIGNED_EN, go to LOAD. Otherwise stay.
  - LOAD: form magnitudes. If sgn, A=|X| and B=|Y| as WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1). Otherwise A=X, B=Y. Store neg = sgn & (X[MSB]^Y[MSB]). Next state MUL_LL.
  - MUL_LL: P_ll = Al*Bl (2H bits). Next state MUL_HH.
  - MUL_HH: P_hh = Ah*Bh (2H bits). Next state MUL_MID.
  - MUL_MID: P_mid = (Ah+Al)*(Bh+Bl). Sums are H+1 bits; product is 2H+2 bits. Next state COMB.
  - COMB: M = P_mid - P_hh - P_ll. M is non-negative and is computed at 2H+2 bits with no truncation.
    - U = (P_hh << WIDTH) + (M << H) + P_ll, computed at 2*WIDTH bits; the upper carry is provably zero.
    - Z <= neg ? -U : U (two's complement, 2*WIDTH bits). done <= 1 for the following cycle. Next state IDLE.
- All three products use one shared (H+1)x(H+1) unsigned multiplier instance, with operands muxed by state.
- Timing: start sampled at edge 0, Z and done registered at edge 5, so done is high in the 5th cycle after acceptance.
  - busy = 1 in LOAD, MUL_LL, MUL_HH, MUL_MID, COMB; 0 in IDLE.
  - done = 1 only in the IDLE cycle following COMB.
- Back-to-back: start=1 during the done cycle is accepted, giving one product per 5 cycles.
- start while busy=1 is ignored. It is not queued and does not disturb the operation.
- X, Y and is_signed changes after acceptance have no effect.
- Z holds its value through subsequent operations until the next done.
- Zero operands, all-ones operands and the most-negative signed value must produce exact results; there is no overflow, since 2*WIDTH bits always suffice.
- Unsigned mode with MSB-set operands is treated as large positive values.

Test Plan:
- WIDTH=8 unsigned: X=200, Y=150, start one cycle -> busy for 5 cycles, then done pulse with Z=16'h7530 (30000); Z holds afterwards.
- WIDTH=8 unsigned: X=8'hFF, Y=8'hFF -> Z=16'hFE01. Then a back-to-back start in the done cycle with X=0, Y=8'hA5 -> next done 5 cycles later with Z=0.
- WIDTH=8 signed: X=8'h80 (-128), Y=8'h7F (127) -> Z=16'hC080 (-16256). Then X=Y=8'h80 -> Z=16'h4000.
- WIDTH=8, SIGNED_EN=0, is_signed=1: X=8'h80, Y=8'h02 -> Z=16'h0100 (unsigned interpretation).
- WIDTH=16 unsigned: X=Y=16'hFFFF -> Z=32'hFFFE0001. Then start pulsed during busy with different operands -> ignored, exactly one done with the original result.
- Reset asserted during MUL_HH -> next cycle busy=0, done=0, Z=0; no done appears. A new start after reset with X=3, Y=5 -> Z=15.

Source files
------------

// File: rtl/karatsuba_seq.sv
// karatsuba_seq: multi-cycle signed/unsigned Karatsuba multiplier sharing one (WIDTH/2+1)-bit multiplier
module karatsuba_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Z
);
    localparam int H = WIDTH / 2;

    if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
        $error("karatsuba_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [2:0] {IDLE, LOAD, MUL_LL, MUL_HH, MUL_MID, COMB} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, a_q, a_d, b_q, b_d;
    logic                 sgn_q, sgn_d, neg_q, neg_d, done_q, done_d;
    logic [WIDTH-1:0]     p_ll_q, p_ll_d, p_hh_q, p_hh_d;
    logic [2*H+1:0]       p_mid_q, p_mid_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic [H:0]           mul_a, mul_b;
    logic [2*H+1:0]       mul_p, m;
    logic [2*WIDTH-1:0]   u;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = MUL_LL;
            MUL_LL:  state_d = MUL_HH;
            MUL_HH:  state_d = MUL_MID;
            MUL_MID: state_d = COMB;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
        done = done_q;
        Z    = z_q;
    end

    // One shared multiplier; the middle term needs the extra carry bit of each half-sum
    always_comb begin
        mul_a = state_q == MUL_LL ? {1'b0, a_q[H-1:0]} :
                state_q == MUL_HH ? {1'b0, a_q[WIDTH-1:H]} :
                {1'b0, a_q[WIDTH-1:H]} + {1'b0, a_q[H-1:0]};
        mul_b = state_q == MUL_LL ? {1'b0, b_q[H-1:0]} :
                state_q == MUL_HH ? {1'b0, b_q[WIDTH-1:H]} :
                {1'b0, b_q[WIDTH-1:H]} + {1'b0, b_q[H-1:0]};
        mul_p = {{(H+1){1'b0}}, mul_a} * {{(H+1){1'b0}}, mul_b};
    end

    always_comb begin
        m = p_mid_q - {2'b00, p_hh_q} - {2'b00, p_ll_q};
        u = {p_hh_q, {WIDTH{1'b0}}} + ({{(WIDTH-2){1'b0}}, m} << H) + {{WIDTH{1'b0}}, p_ll_q};
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        p_ll_d  = p_ll_q;
        p_hh_d  = p_hh_q;
        p_mid_d = p_mid_q;
        z_d     = z_q;
        done_d  = state_q == COMB;
        if (state_q == IDLE && start) begin
            x_d   = X;
            y_d   = Y;
            sgn_d = is_signed & SIGNED_EN;
        end
        if (state_q == LOAD) begin
            a_d   = (sgn_q && x_q[WIDTH-1]) ? -x_q : x_q;
            b_d   = (sgn_q && y_q[WIDTH-1]) ? -y_q : y_q;
            neg_d = sgn_q & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
        end
        if (state_q == MUL_LL) p_ll_d = mul_p[2*H-1:0];
        if (state_q == MUL_HH) p_hh_d = mul_p[2*H-1:0];
        if (state_q == MUL_MID) p_mid_d = mul_p;
        if (state_q == COMB) z_d = neg_q ? -u : u;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            p_ll_q  <= '0;
            p_hh_q  <= '0;
            p_mid_q <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            p_ll_q  <= p_ll_d;
            p_hh_q  <= p_hh_d;
            p_mid_q <= p_mid_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_karatsuba_seq.sv
// tb_karatsuba_seq: directed checks of karatsuba_seq at WIDTH 8 (signed/unsigned-only) and WIDTH 16
module tb_karatsuba_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start, busy, done;
    logic        sgn;
    logic [15:0] xv, yv;
    logic [15:0] z8, z8u;
    logic [31:0] z16;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    karatsuba_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_s8 (
        .clock(clk), .reset(rst), .start(start[0]), .is_signed(sgn), .X(xv[7:0]), .Y(yv[7:0]),
        .busy(busy[0]), .done(done[0]), .Z(z8));
    karatsuba_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) u_u8 (
        .clock(clk), .reset(rst), .start(start[1]), .is_signed(sgn), .X(xv[7:0]), .Y(yv[7:0]),
        .busy(busy[1]), .done(done[1]), .Z(z8u));
    karatsuba_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) u_16 (
        .clock(clk), .reset(rst), .start(start[2]), .is_signed(sgn), .X(xv), .Y(yv),
        .busy(busy[2]), .done(done[2]), .Z(z16));

    function automatic logic [31:0] zof(input int s);
        return s == 0 ? {16'h0, z8} : s == 1 ? {16'h0, z8u} : z16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge, then inputs are scrambled
    task automatic issue(input int s, input logic [15:0] x, input logic [15:0] y, input logic is);
        xv = x;
        yv = y;
        sgn = is;
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        xv = 16'($urandom);
        yv = 16'($urandom);
        sgn = ~is;
    endtask

    task automatic op(input string tag, input int s, input logic [15:0] x, input logic [15:0] y,
                      input logic is, input logic [31:0] exp, input bit hold);
        int n = 0;
        bit bb = 1'b0;
        issue(s, x, y, is);
        while (!done[s] && n < 20) begin
            bb = bb | !busy[s];
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 5);
        chk({tag, " busy-gap"}, {31'b0, bb}, 0);
        chk({tag, " busy@done"}, {31'b0, busy[s]}, 0);
        chk({tag, " Z"}, zof(s), exp);
        if (hold) begin
            @(negedge clk);
            chk({tag, " done-pulse"}, {31'b0, done[s]}, 0);
            repeat (3) @(negedge clk);
            chk({tag, " Z-hold"}, zof(s), exp);
        end
    endtask

    initial begin
        int dc, dn;
        rst = 1'b1;
        start = '0;
        sgn = 1'b0;
        xv = '0;
        yv = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset busy", {31'b0, busy[s]}, 0);
            chk("reset done", {31'b0, done[s]}, 0);
            chk("reset Z", zof(s), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        op("u200x150", 0, 16'd200, 16'd150, 1'b0, 32'h7530, 1'b1);
        op("uFFxFF", 0, 16'hFF, 16'hFF, 1'b0, 32'hFE01, 1'b0);
        op("b2b 0xA5", 0, 16'h00, 16'hA5, 1'b0, 32'h0000, 1'b1);
        op("s80x7F", 0, 16'h80, 16'h7F, 1'b1, 32'hC080, 1'b1);
        op("s80x80", 0, 16'h80, 16'h80, 1'b1, 32'h4000, 1'b1);
        op("sFDx05", 0, 16'hFD, 16'h05, 1'b1, 32'hFFF1, 1'b1);
        op("uFDx05", 0, 16'hFD, 16'h05, 1'b0, 32'h04F1, 1'b1);
        op("nosign 80x02", 1, 16'h80, 16'h02, 1'b1, 32'h0100, 1'b1);
        op("w16 sFFFEx3", 2, 16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA, 1'b1);

        // start pulsed while busy must be ignored
        issue(2, 16'hFFFF, 16'hFFFF, 1'b0);
        dc = 0;
        dn = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 2) begin
                xv = 16'h1234;
                yv = 16'h0002;
                start[2] = 1'b1;
            end
            if (i == 3) start[2] = 1'b0;
            @(negedge clk);
            if (done[2]) begin
                dc++;
                dn = i;
            end
        end
        chk("w16 ignore done-count", dc, 1);
        chk("w16 ignore latency", dn, 5);
        chk("w16 FFFFxFFFF Z", z16, 32'hFFFE0001);

        // reset in MUL_HH aborts without a done
        issue(0, 16'h11, 16'h22, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'b0, busy[0]}, 0);
        chk("abort done", {31'b0, done[0]}, 0);
        chk("abort Z", {16'h0, z8}, 0);
        rst = 1'b0;
        dc = 0;
        repeat (10) begin
            @(negedge clk);
            if (done[0]) dc++;
        end
        chk("abort no-done", dc, 0);
        op("after-reset 3x5", 0, 16'd3, 16'd5, 1'b0, 32'd15, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
